// File: rtl/score_pkg.sv
// score_pkg: shared types and constants for the score arbiter slice.
//   SCORE_W       width of the unsigned game score
//   SCORE_MAX     largest representable score (saturation ceiling)
//   DEF_NUM_COLS  default number of arrow columns
//   game_state_t  game FSM encoding
//   delta_t       signed per-column score change
//   sat_add8      signed add clamped to -128..+127 (used to merge deltas)
package score_pkg;

  localparam int SCORE_W = 8;
  localparam logic [SCORE_W-1:0] SCORE_MAX = 8'd255;
  localparam int DEF_NUM_COLS = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PLAY,
    S_WON
  } game_state_t;

  typedef logic signed [7:0] delta_t;

  // Signed sum of two deltas, clamped to the delta_t range.
  function automatic delta_t sat_add8(input delta_t a, input delta_t b);
    logic signed [8:0] sum9;
    sum9 = {a[7], a} + {b[7], b};
    if (sum9 > 9'sd127) begin
      return 8'sh7f;
    end else if (sum9 < -9'sd128) begin
      return 8'sh80;
    end
    return sum9[7:0];
  endfunction

endpackage

// File: rtl/score_arbiter_if.sv
// score_arbiter_if: bundle between the column scorers / display and the
// score arbiter.
//   start       one-cycle pulse, begins a new game
//   delta       packed per-column signed deltas, column i at [8*i +: 8]
//   totalscore  accumulated unsigned score
//   grant       one-hot column being applied at the coming edge
//   busy        any pending slot valid
//   playing     game in PLAY
//   won         game in WON
// master: scorer/game side; slave: the arbiter.
interface score_arbiter_if
  import score_pkg::*;
#(
  parameter int NUM_COLS = DEF_NUM_COLS
);
  logic                  start;
  logic [8*NUM_COLS-1:0] delta;
  logic [SCORE_W-1:0]    totalscore;
  logic [NUM_COLS-1:0]   grant;
  logic                  busy;
  logic                  playing;
  logic                  won;

  modport master (
    output start, delta,
    input  totalscore, grant, busy, playing, won
  );

  modport slave (
    input  start, delta,
    output totalscore, grant, busy, playing, won
  );
endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: purely combinational round-robin picker.
//   req    request vector, one bit per requester
//   ptr    index with highest priority this cycle
//   grant  one-hot: first requester at or after ptr (wrapping), 0 if none
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant
);

  always_comb begin
    logic          found;
    logic [PW-1:0] idx;
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int off = 0; off < N; off++) begin
      idx = PW'((int'(ptr) + off) % N);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/score_arbiter.sv
// score_arbiter: shares the single game score register between the
// per-column scorers. Each nonzero column delta lands in that column's
// pending slot; one slot per cycle is applied to the score in round-robin
// order, saturating to 0..255. Also runs the IDLE/PLAY/WON game FSM.
//   clk    system clock
//   reset  synchronous active-high reset
//   bus    score_arbiter_if slave (start, delta in; totalscore, grant,
//          busy, playing, won out)
module score_arbiter
  import score_pkg::*;
#(
  parameter int                 NUM_COLS  = DEF_NUM_COLS,
  parameter logic [SCORE_W-1:0] WIN_SCORE = SCORE_MAX
) (
  input logic            clk,
  input logic            reset,
  score_arbiter_if.slave bus
);

  localparam int PW = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;

  game_state_t         state_reg;
  logic [SCORE_W-1:0]  total_reg;
  logic [NUM_COLS-1:0] slot_valid_reg;
  delta_t              slot_val_reg [NUM_COLS];
  logic [PW-1:0]       ptr_reg;

  logic [NUM_COLS-1:0] req;
  logic [NUM_COLS-1:0] grant;
  delta_t              col_delta [NUM_COLS];
  delta_t              gnt_val;
  logic [PW-1:0]       gnt_idx;
  logic [PW-1:0]       ptr_next;
  logic signed [9:0]   sum10;
  logic [SCORE_W-1:0]  applied;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_COLS; gi++) begin : g_unpack
      assign col_delta[gi] = bus.delta[8*gi +: 8];
    end
  endgenerate

  // Arbitration only happens while a game is running.
  assign req = (state_reg == S_PLAY) ? slot_valid_reg : '0;

  rr_arbiter #(.N(NUM_COLS)) u_rr (
    .req   (req),
    .ptr   (ptr_reg),
    .grant (grant)
  );

  always_comb begin
    gnt_val = '0;
    gnt_idx = '0;
    for (int i = 0; i < NUM_COLS; i++) begin
      if (grant[i]) begin
        gnt_val = slot_val_reg[i];
        gnt_idx = PW'(i);
      end
    end
  end

  assign ptr_next = (gnt_idx == PW'(NUM_COLS - 1)) ? '0 : gnt_idx + 1'b1;

  // 10-bit signed: unsigned score zero-extended plus sign-extended delta.
  assign sum10 = $signed({2'b00, total_reg}) + $signed({{2{gnt_val[7]}}, gnt_val});

  always_comb begin
    if (sum10 < 10'sd0) begin
      applied = '0;
    end else if (sum10 > 10'sd255) begin
      applied = SCORE_MAX;
    end else begin
      applied = sum10[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= S_IDLE;
      total_reg      <= '0;
      slot_valid_reg <= '0;
      ptr_reg        <= '0;
      for (int i = 0; i < NUM_COLS; i++) slot_val_reg[i] <= '0;
    end else begin
      case (state_reg)
        S_IDLE, S_WON: begin
          if (bus.start) begin
            state_reg      <= S_PLAY;
            total_reg      <= '0;
            slot_valid_reg <= '0;
            ptr_reg        <= '0;
            for (int i = 0; i < NUM_COLS; i++) slot_val_reg[i] <= '0;
          end
        end

        S_PLAY: begin
          for (int i = 0; i < NUM_COLS; i++) begin
            if (col_delta[i] != '0) begin
              // A slot being drained this cycle reloads instead of merging,
              // so the granted value is applied exactly once.
              if (slot_valid_reg[i] && !grant[i]) begin
                slot_val_reg[i] <= sat_add8(slot_val_reg[i], col_delta[i]);
              end else begin
                slot_val_reg[i] <= col_delta[i];
              end
              slot_valid_reg[i] <= 1'b1;
            end else if (grant[i]) begin
              slot_valid_reg[i] <= 1'b0;
            end
          end

          if (|grant) begin
            total_reg <= applied;
            ptr_reg   <= ptr_next;
            // Winning drops everything still pending, including deltas
            // captured on this same edge.
            if (applied == WIN_SCORE) begin
              state_reg      <= S_WON;
              slot_valid_reg <= '0;
              for (int i = 0; i < NUM_COLS; i++) slot_val_reg[i] <= '0;
            end
          end
        end

        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign bus.totalscore = total_reg;
  assign bus.grant      = grant;
  assign bus.busy       = |slot_valid_reg;
  assign bus.playing    = (state_reg == S_PLAY);
  assign bus.won        = (state_reg == S_WON);

endmodule

// File: tb/tb_score_arbiter.sv
// tb_score_arbiter: directed bench for score_arbiter. Expected (grant,
// score) pairs are queued as each stimulus step is driven and popped as
// the DUT grants columns.
module tb_score_arbiter;
  import score_pkg::*;

  typedef struct {
    logic [3:0] g;
    logic [7:0] s;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;
  exp_t sb [$];

  score_arbiter_if #(.NUM_COLS(4)) bus ();

  score_arbiter #(.NUM_COLS(4), .WIN_SCORE(8'd255)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] pk(input int d0, input int d1, input int d2, input int d3);
    return {8'(d3), 8'(d2), 8'(d1), 8'(d0)};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [3:0] g, input logic [7:0] s);
    exp_t e;
    e.g = g;
    e.s = s;
    sb.push_back(e);
  endtask

  // Holds d for exactly one rising edge; returns at the following negedge
  // with d still on the bus so the caller decides the next value.
  task automatic cycle_drive(input logic [31:0] d);
    bus.delta = d;
    @(negedge clk);
  endtask

  // Drives 'first' for the current cycle, then zeros, while popping one
  // expected entry per observed grant.
  task automatic drain(input logic [31:0] first);
    exp_t e;
    int   budget;
    budget = 20;
    bus.delta = first;
    while (sb.size() > 0) begin
      if (budget == 0) begin
        check("drain_timeout_pending", 32'(sb.size()), 32'd0);
        sb.delete();
        break;
      end
      if (bus.grant != '0) begin
        e = sb.pop_front();
        check("grant", 32'(bus.grant), 32'(e.g));
        @(negedge clk);
        bus.delta = '0;
        budget--;
        check("score", 32'(bus.totalscore), 32'(e.s));
      end else begin
        @(negedge clk);
        bus.delta = '0;
        budget--;
      end
    end
    bus.delta = '0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  initial begin
    bus.start = 1'b0;
    bus.delta = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Reset state
    check("rst_score", 32'(bus.totalscore), 32'd0);
    check("rst_grant", 32'(bus.grant), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_playing", 32'(bus.playing), 32'd0);
    check("rst_won", 32'(bus.won), 32'd0);

    // Deltas in IDLE are not captured
    cycle_drive(pk(3, 0, 0, 0));
    bus.delta = '0;
    @(negedge clk);
    check("idle_busy", 32'(bus.busy), 32'd0);

    // 1: simple capture and apply
    pulse_start();
    check("start_playing", 32'(bus.playing), 32'd1);
    push(4'b0001, 8'd2);
    cycle_drive(pk(2, 0, 0, 0));
    check("t1_busy_pending", 32'(bus.busy), 32'd1);
    drain('0);
    check("t1_busy_done", 32'(bus.busy), 32'd0);

    // start while playing is ignored
    pulse_start();
    check("start_in_play_score", 32'(bus.totalscore), 32'd2);

    // 2: four simultaneous deltas, pointer back to 0 first
    push(4'b1000, 8'd10);
    cycle_drive(pk(0, 0, 0, 8));
    drain('0);
    push(4'b0001, 8'd11);
    push(4'b0010, 8'd13);
    push(4'b0100, 8'd11);
    push(4'b1000, 8'd12);
    cycle_drive(pk(1, 2, -2, 1));
    drain('0);
    check("t2_busy", 32'(bus.busy), 32'd0);

    // 3: underflow clamps to 0
    push(4'b1000, 8'd1);
    cycle_drive(pk(0, 0, 0, -11));
    drain('0);
    push(4'b0100, 8'd0);
    cycle_drive(pk(0, 0, -2, 0));
    drain('0);
    push(4'b0100, 8'd0);
    cycle_drive(pk(0, 0, -2, 0));
    drain('0);

    // 4: reach 255 -> WON, pending col3 dropped
    push(4'b1000, 8'd127);
    cycle_drive(pk(0, 0, 0, 127));
    drain('0);
    push(4'b0001, 8'd254);
    cycle_drive(pk(127, 0, 0, 0));
    drain('0);
    push(4'b0010, 8'd255);
    cycle_drive(pk(0, 2, 0, 1));
    drain('0);
    check("t4_won", 32'(bus.won), 32'd1);
    check("t4_playing", 32'(bus.playing), 32'd0);
    check("t4_busy", 32'(bus.busy), 32'd0);
    check("t4_grant", 32'(bus.grant), 32'd0);
    cycle_drive(pk(5, 0, 0, 0));
    bus.delta = '0;
    @(negedge clk);
    check("t4_won_ignore_busy", 32'(bus.busy), 32'd0);
    check("t4_won_ignore_score", 32'(bus.totalscore), 32'd255);
    pulse_start();
    check("t4_restart_playing", 32'(bus.playing), 32'd1);
    check("t4_restart_score", 32'(bus.totalscore), 32'd0);

    // 5a: merge into an ungranted slot (pointer moved to 3 first)
    push(4'b0100, 8'd1);
    cycle_drive(pk(0, 0, 1, 0));
    drain('0);
    push(4'b1000, 8'd2);
    push(4'b0001, 8'd5);
    cycle_drive(pk(2, 0, 0, 1));
    drain(pk(1, 0, 0, 0));
    check("t5a_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    check("t5a_score_once", 32'(bus.totalscore), 32'd5);

    // 5b: new delta in the granting cycle reloads the slot
    push(4'b0001, 8'd7);
    push(4'b0001, 8'd8);
    cycle_drive(pk(2, 0, 0, 0));
    drain(pk(1, 0, 0, 0));
    check("t5b_busy", 32'(bus.busy), 32'd0);

    // 6: reset mid-game with three pending slots
    push(4'b0010, 8'd40);
    cycle_drive(pk(0, 32, 0, 0));
    drain('0);
    cycle_drive(pk(1, 1, 1, 0));
    bus.delta = '0;
    check("t6_busy_pending", 32'(bus.busy), 32'd1);
    check("t6_grant_ptr2", 32'(bus.grant), 32'b0100);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("t6_playing", 32'(bus.playing), 32'd0);
    check("t6_won", 32'(bus.won), 32'd0);
    check("t6_score", 32'(bus.totalscore), 32'd0);
    check("t6_busy", 32'(bus.busy), 32'd0);
    check("t6_grant", 32'(bus.grant), 32'd0);
    cycle_drive(pk(5, 0, 0, 0));
    bus.delta = '0;
    @(negedge clk);
    check("t6_idle_busy", 32'(bus.busy), 32'd0);
    check("t6_idle_score", 32'(bus.totalscore), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/score_arbiter.md
Name: score_arbiter

Overview:
Shares the single 8-bit game score register between the per-column scoring blocks of the rhythm game. Each column's scorer emits a one-cycle signed score delta once per 16-cycle beat.
- This block buffers each delta in a per-column pending slot.
- It applies one pending slot per cycle in round-robin order, saturating the result to 0..255.
- It runs the game FSM (IDLE/PLAY/WON) and feeds the total score back to all scorers and to the display logic.

Parameters:
NUM_COLS, 4, number of arrow columns / requesters
WIN_SCORE, 8'd255, total score that ends the game as won

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse; begins a new game from IDLE or WON
delta  in  8*NUM_COLS  per-column signed two's-complement score change; column i is delta[8*i+7:8*i]; nonzero for at most one cycle per beat
totalscore  out  8  unsigned accumulated score, fed back to the column scorers
grant  out  NUM_COLS  one-hot; column whose pending delta is applied at the coming edge; 0 if none
busy  out  1  any pending slot valid
playing  out  1  state == PLAY
won  out  1  state == WON

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high. All state updates on posedge clk.
- Reset values: state=IDLE, totalscore=0, all pending slots invalid/0, RR pointer=0, grant=0, busy=0, playing=0, won=0.
- FSM transitions:
  - IDLE --start--> PLAY. On that edge: totalscore<=0, slots cleared, pointer<=0.
  - PLAY --(applied result == WIN_SCORE)--> WON. On that edge all pending slots are cleared.
  - WON --start--> PLAY, with the same clearing as IDLE->PLAY.
  - start while in PLAY: ignored.
- Capture:
  - Only in PLAY. For each column, a nonzero delta at cycle t sets slot valid with value=delta at edge t.
  - Zero deltas are never captured.
  - In IDLE/WON, delta is ignored.
- Merge:
  - If delta arrives for a column whose slot is valid and not granted this cycle, the slot becomes the signed sum clamped to -128..+127.
  - If the slot is granted in the same cycle, the granted value is applied and the slot reloads with the new delta. No merge, no loss.
- Arbitration:
  - Combinational grant = first valid slot at or after the pointer, wrapping modulo NUM_COLS. grant is only asserted in PLAY.
  - On a grant to column k: slot k invalidated, pointer<=(k+1) mod NUM_COLS.
  - No grant: pointer holds.
- Apply: totalscore <= clamp(totalscore + sign-extended slot value, 0, 255), computed in 10-bit signed arithmetic.
  - Underflow clamps to 0 (e.g. 1 + -2 = 0).
  - Overflow clamps to 255.
- Latency:
  - A delta at cycle t is captured at edge t and is visible as pending in cycle t+1.
  - With no contention it is granted in cycle t+1 and reflected in totalscore after edge t+1.
  - Worst case with NUM_COLS simultaneous deltas: the last is applied NUM_COLS cycles after capture. This is always fewer than 16, so slots drain before the next beat.
- busy = OR of slot valid bits (combinational).
- Reset mid-game: returns to IDLE; pending deltas are dropped; score becomes 0.

Decomposition:
- Package score_pkg:
  - SCORE_W=8
  - SCORE_MAX=8'd255
  - default NUM_COLS=4
  - typedef enum logic [1:0] {S_IDLE, S_PLAY, S_WON} game_state_t
  - typedef logic signed [7:0] delta_t
- Sub-module rr_arbiter: parameter N; inputs req[N] and the pointer; output a one-hot grant. Purely combinational.
- The pointer, slots, accumulator and FSM stay in score_arbiter.

Test Plan:
1. reset, then start; in PLAY, col0 delta=+2 at cycle t -> grant=0001 in cycle t+1; totalscore=2 after edge t+1; busy low at t+2.
2. Score 10, cols 0..3 deltas +1,+2,-2,+1 in the same cycle, pointer=0 -> grants 0001,0010,0100,1000 on consecutive cycles; totalscore 11,13,11,12; pointer ends at 0.
3. totalscore=1, col2 delta=-2 -> totalscore=0. Then another -2 -> stays 0.
4. totalscore=254, col1 +2 while col3 +1 pending behind it -> score reaches 255, state WON, won=1, col3 slot cleared, grant=0. Subsequent deltas are ignored; start -> PLAY, score 0.
5. Col0 slot holds +2 ungranted (col3 is granted first, pointer=3) and col0 receives +1 -> slot becomes +3, applied once. In a separate case, col0 receives +1 in the cycle its +2 is granted -> +2 applied, then +1 applied next cycle.
6. Reset asserted while 3 slots are pending and score=40 -> next cycle: IDLE, score 0, busy 0, grant 0. Deltas in IDLE are not captured.
